// File: rtl/hazard_ctrl.sv
// RVX10 hazard control: EX forwarding, load-use bubbles, long-op E occupancy, branch flushes.
// All outputs are combinational from the current inputs and counters; stalls hold upstream stages, never drop work.
module hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int LOAD_STALL = 1,
  parameter int LONG_LAT   = 4,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] Rs1D,
  input  logic [RA_W-1:0] Rs2D,
  input  logic [RA_W-1:0] Rs1E,
  input  logic [RA_W-1:0] Rs2E,
  input  logic [RA_W-1:0] RdE,
  input  logic [RA_W-1:0] RdM,
  input  logic [RA_W-1:0] RdW,
  input  logic            MemReadE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            LongOpE,
  input  logic            PCSrcE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            busy
);

  typedef enum logic {IDLE, BUSY} loStateT;

  localparam logic             LO_EN   = (LONG_LAT >= 2);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] LO_INIT = (LONG_LAT >= 2) ? CNT_W'(LONG_LAT - 2) : '0;

  loStateT          state, stateNext;
  logic [CNT_W-1:0] ldCnt, ldCntNext;
  logic [CNT_W-1:0] loCnt, loCntNext;
  logic             ldActive, ldHaz, ldStall, loStall, branch;

  function automatic logic [1:0] fwdSel(input logic [RA_W-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs))
      return 2'b01;
    return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ldCnt <= '0;
      loCnt <= '0;
    end else begin
      state <= stateNext;
      ldCnt <= ldCntNext;
      loCnt <= loCntNext;
    end
  end

  always_comb begin
    ldActive  = (ldCnt != '0);
    // A new hazard is only looked for once the previous bubble train has drained.
    ldHaz     = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !ldActive;
    ldStall   = ldHaz || ldActive;
    ldCntNext = ldActive ? (ldCnt - CNT_W'(1)) : (ldHaz ? LD_INIT : '0);

    stateNext = state;
    loCntNext = loCnt;
    loStall   = 1'b0;
    case (state)
      IDLE: begin
        if (LongOpE && LO_EN) begin
          loStall   = 1'b1;
          stateNext = BUSY;
          loCntNext = LO_INIT;
        end
      end
      BUSY: begin
        if (loCnt != '0) begin
          loStall   = 1'b1;
          loCntNext = loCnt - CNT_W'(1);
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // The branch in E is not final until the long op lets E advance.
    branch = PCSrcE && !loStall;
  end

  assign stallF    = !reset && (ldStall || loStall);
  assign stallD    = !reset && (ldStall || loStall);
  assign stallE    = !reset && loStall;
  assign flushD    = !reset && branch;
  assign flushE    = !reset && (ldStall || branch) && !loStall;
  assign flushM    = !reset && loStall;
  assign forwardAE = reset ? 2'b00 : fwdSel(Rs1E);
  assign forwardBE = reset ? 2'b00 : fwdSel(Rs2E);
  assign busy      = !reset && (state == BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_STALL=3/LONG_LAT=4 and LOAD_STALL=1/LONG_LAT=1) on shared inputs.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       MemReadE, RegWriteM, RegWriteW, LongOpE, PCSrcE;

  logic       aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aBusy;
  logic [1:0] aFwdA, aFwdB;
  logic       bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM, bBusy;
  logic [1:0] bFwdA, bFwdB;
  logic [10:0] outA, outB;

  int checks = 0;
  int errors = 0;
  int ldA = 0, loA = 0, ldB = 0, loB = 0;

  // Vector layout: stallF stallD stallE flushD flushE flushM fwdA[1:0] fwdB[1:0] busy
  localparam logic [10:0] LD   = 11'b11001000000;
  localparam logic [10:0] LO   = 11'b11100100000;
  localparam logic [10:0] BR   = 11'b00011000000;
  localparam logic [10:0] BSY  = 11'b00000000001;

  always #5 clk = ~clk;

  assign outA = {aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aFwdA, aFwdB, aBusy};
  assign outB = {bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM, bFwdA, bFwdB, bBusy};

  hazard_ctrl #(.RA_W(5), .LOAD_STALL(3), .LONG_LAT(4), .CNT_W(4)) dutA (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .MemReadE(MemReadE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LongOpE(LongOpE), .PCSrcE(PCSrcE),
    .stallF(aStallF), .stallD(aStallD), .stallE(aStallE), .flushD(aFlushD),
    .flushE(aFlushE), .flushM(aFlushM), .forwardAE(aFwdA), .forwardBE(aFwdB), .busy(aBusy));

  hazard_ctrl #(.RA_W(5), .LOAD_STALL(1), .LONG_LAT(1), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .MemReadE(MemReadE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LongOpE(LongOpE), .PCSrcE(PCSrcE),
    .stallF(bStallF), .stallD(bStallD), .stallE(bStallE), .flushD(bFlushD),
    .flushE(bFlushE), .flushM(bFlushM), .forwardAE(bFwdA), .forwardBE(bFwdB), .busy(bBusy));

  // Reference model. ldLeft = bubbles still owed after this cycle's decision;
  // loAge = how many cycles the current long op has already spent in E (0 = none).
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic loadHaz(input int ldLeft);
    return ldLeft == 0 && MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic logic longStall(input int T, input int loAge);
    return (loAge == 0 && LongOpE && T >= 2) || (loAge > 0 && loAge + 1 < T);
  endfunction

  function automatic logic [10:0] model(input int T, input int ldLeft, input int loAge);
    logic ldSt, loSt, br;
    ldSt = ldLeft > 0 || loadHaz(ldLeft);
    loSt = longStall(T, loAge);
    br   = PCSrcE && !loSt;
    return {ldSt | loSt, ldSt | loSt, loSt, br, (ldSt | br) & !loSt, loSt,
            fwd(Rs1E), fwd(Rs2E), loAge > 0};
  endfunction

  task automatic advance(input int L, input int T, input int ldIn, input int loIn,
                         output int ldOut, output int loOut);
    if (ldIn > 0)             ldOut = ldIn - 1;
    else if (loadHaz(ldIn))   ldOut = L - 1;
    else                      ldOut = 0;
    if (loIn == 0)            loOut = (LongOpE && T >= 2) ? 1 : 0;
    else                      loOut = (loIn + 1 < T) ? loIn + 1 : 0;
  endtask

  task automatic idleInputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    MemReadE = 0; RegWriteM = 0; RegWriteW = 0; LongOpE = 0; PCSrcE = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    #3;
    RegWriteM = 1; RdM = 5; Rs1E = 5; MemReadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1; LongOpE = 1;
    #1;
    checks++;
    if (outA !== 11'd0) begin errors++; $display("FAIL reset_outA got %b want %b", outA, 11'd0); end
    checks++;
    if (outB !== 11'd0) begin errors++; $display("FAIL reset_outB got %b want %b", outB, 11'd0); end
    idleInputs();
    @(negedge clk);
    reset = 1'b0;
    cyc();
    #3;
    checks++;
    if (outA !== 11'd0) begin errors++; $display("FAIL reset_idle got %b want %b", outA, 11'd0); end
  endtask

  task automatic test_forward();
    cyc();
    RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
    #1;
    checks++;
    if (outA !== 11'b00000010100) begin errors++; $display("FAIL fwd_m_prio got %b want %b", outA, 11'b00000010100); end
    RegWriteM = 0;
    #1;
    checks++;
    if (outA !== 11'b00000001010) begin errors++; $display("FAIL fwd_w got %b want %b", outA, 11'b00000001010); end
    Rs2E = 6; RegWriteM = 1; RdM = 6;
    #1;
    checks++;
    if (outB !== 11'b00000001100) begin errors++; $display("FAIL fwd_split got %b want %b", outB, 11'b00000001100); end
    RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    #1;
    checks++;
    if (outA !== 11'd0) begin errors++; $display("FAIL fwd_zero got %b want %b", outA, 11'd0); end
    idleInputs();
  endtask

  task automatic test_load_use();
    logic [10:0] eA, eB;
    cyc();
    RdE = 7; Rs2D = 7;
    for (int c = 0; c < 4; c++) begin
      MemReadE = (c == 0);
      #3;
      eA = (c < 3) ? LD : 11'd0;
      eB = (c < 1) ? LD : 11'd0;
      checks++;
      if (outA !== eA) begin errors++; $display("FAIL load_A c%0d got %b want %b", c, outA, eA); end
      checks++;
      if (outB !== eB) begin errors++; $display("FAIL load_B c%0d got %b want %b", c, outB, eB); end
      cyc();
    end
    idleInputs();
  endtask

  task automatic test_long_op();
    logic [10:0] eA, eB;
    cyc();
    for (int c = 1; c <= 5; c++) begin
      LongOpE = (c <= 4);
      PCSrcE  = (c == 2 || c == 4);
      #3;
      case (c)
        1:       eA = LO;
        2, 3:    eA = LO | BSY;
        4:       eA = BR | BSY;
        default: eA = 11'd0;
      endcase
      eB = PCSrcE ? BR : 11'd0;
      checks++;
      if (outA !== eA) begin errors++; $display("FAIL longop_A c%0d got %b want %b", c, outA, eA); end
      checks++;
      if (outB !== eB) begin errors++; $display("FAIL longop_B c%0d got %b want %b", c, outB, eB); end
      cyc();
    end
    idleInputs();
  endtask

  task automatic test_branch();
    cyc();
    PCSrcE = 1;
    #3;
    checks++;
    if (outA !== BR) begin errors++; $display("FAIL branch_idle got %b want %b", outA, BR); end
    idleInputs();
  endtask

  task automatic test_reset_mid();
    cyc();
    LongOpE = 1; MemReadE = 1; RdE = 7; Rs1D = 7;
    #3;
    checks++;
    if (outA !== LO) begin errors++; $display("FAIL ld_lo_overlap got %b want %b", outA, LO); end
    cyc();
    MemReadE = 0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (outA !== 11'd0) begin errors++; $display("FAIL reset_mid_A got %b want %b", outA, 11'd0); end
    cyc();
    idleInputs();
    #2;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cyc();
      #3;
      checks++;
      if (outA !== 11'd0) begin errors++; $display("FAIL post_reset c%0d got %b want %b", c, outA, 11'd0); end
    end
  endtask

  task automatic test_zero_reg();
    cyc();
    MemReadE = 1; RdE = 0; Rs1D = 0; Rs2D = 0; RegWriteM = 1; RdM = 0; RegWriteW = 1; RdW = 0;
    #3;
    checks++;
    if (outA !== 11'd0) begin errors++; $display("FAIL zero_reg_A got %b want %b", outA, 11'd0); end
    checks++;
    if (outB !== 11'd0) begin errors++; $display("FAIL zero_reg_B got %b want %b", outB, 11'd0); end
    idleInputs();
  endtask

  task automatic test_random();
    logic [10:0] eA, eB;
    int nA, mA, nB, mB;
    idleInputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    ldA = 0; loA = 0; ldB = 0; loB = 0;
    for (int i = 0; i < 600; i++) begin
      cyc();
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      MemReadE  = ($urandom_range(0, 3) == 0);
      RegWriteM = $urandom_range(0, 1) == 1;
      RegWriteW = $urandom_range(0, 1) == 1;
      LongOpE   = ($urandom_range(0, 6) == 0);
      PCSrcE    = ($urandom_range(0, 6) == 0);
      #3;
      eA = model(4, ldA, loA);
      eB = model(1, ldB, loB);
      checks++;
      if (outA !== eA) begin errors++; $display("FAIL rand_A i%0d got %b want %b", i, outA, eA); end
      checks++;
      if (outB !== eB) begin errors++; $display("FAIL rand_B i%0d got %b want %b", i, outB, eB); end
      advance(3, 4, ldA, loA, nA, mA);
      advance(1, 1, ldB, loB, nB, mB);
      ldA = nA; loA = mA; ldB = nB; loB = mB;
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_long_op();
    test_branch();
    test_reset_mid();
    test_zero_reg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
